word_assembler: RTL and testbench

Parametrised successor to the two-nibble sequencer/data-path pair. It assembles `NCHUNKS` consecutive `IN_W`-bit input chunks into one `IN_W*NCHUNKS`-bit word and presents the word with a valid/ready output handshake. It adds three things the original pair does not have:

- input stall support;
- a shadowed output register, so that `DATA_OUT` only changes on word completion;
- a synchronous abort.

It sits between the chunk-serial input source and the word-wide consumer.

---
 rtl/word_assembler.sv | 132 +++++++++++++
 tb/tb_word_assembler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_assembler.sv
// word_assembler: collects NCHUNKS consecutive IN_W-bit chunks into one
// IN_W*NCHUNKS-bit word and offers it with a valid/ready handshake.
// DATA_OUT is a shadow register that only changes when a word completes.
//
// Ports:
//   CLK        clock, rising edge active
//   RESET      asynchronous active-low reset
//   valid      DATA_IN carries a chunk to capture this cycle
//   DATA_IN    input chunk (IN_W bits)
//   abort      synchronous discard of the partial word / pending output
//   op_ready   consumer accepts DATA_OUT this cycle
//   en         one-hot slot strobe for the capture at the next edge (comb)
//   op_valid   DATA_OUT holds a completed, unconsumed word
//   DATA_OUT   last completed word
//   chunk_cnt  chunks captured into the current partial word
//   busy       partial word in progress
module word_assembler #(
  parameter int unsigned IN_W      = 4,
  parameter int unsigned NCHUNKS   = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  valid,
  input  logic [IN_W-1:0]                       DATA_IN,
  input  logic                                  abort,
  input  logic                                  op_ready,
  output logic [NCHUNKS-1:0]                    en,
  output logic                                  op_valid,
  output logic [IN_W*NCHUNKS-1:0]               DATA_OUT,
  output logic [$clog2(NCHUNKS+1)-1:0]          chunk_cnt,
  output logic                                  busy
);

  localparam int unsigned W  = IN_W * NCHUNKS;
  localparam int unsigned CW = $clog2(NCHUNKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            opv_q, opv_d;
  logic            capture;
  logic [CW-1:0]   idx;
  logic [NCHUNKS-1:0] en_c;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      dout_q  <= '0;
      opv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      dout_q  <= dout_d;
      opv_q   <= opv_d;
    end
  end

  // Next-state, capture decision and slot strobe
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    dout_d  = dout_q;
    opv_d   = opv_q;
    capture = 1'b0;
    idx     = '0;
    en_c    = '0;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      opv_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: capture = valid;
        LOAD: begin
          capture = valid;
          idx     = cnt_q;
        end
        DONE: begin
          // Held word blocks new captures until the consumer takes it
          if (op_ready) begin
            opv_d   = 1'b0;
            capture = valid;
            if (!valid) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (capture) begin
      for (int unsigned s = 0; s < NCHUNKS; s++) begin
        if (CW'((MSB_FIRST != 0) ? (NCHUNKS - 1 - s) : s) == idx) begin
          asm_d[s*IN_W +: IN_W] = DATA_IN;
          en_c[s]               = 1'b1;
        end
      end
      if (idx == CW'(NCHUNKS - 1)) begin
        // asm_d already includes the chunk merged this cycle
        dout_d  = asm_d;
        opv_d   = 1'b1;
        cnt_d   = '0;
        state_d = DONE;
      end else begin
        cnt_d   = idx + CW'(1);
        state_d = LOAD;
      end
    end

    if (!RESET) en_c = '0;
  end

  assign en        = en_c;
  assign op_valid  = opv_q;
  assign DATA_OUT  = dout_q;
  assign chunk_cnt = cnt_q;
  assign busy      = (state_q == LOAD);

endmodule

// File: tb/tb_word_assembler.sv
// Directed bench for word_assembler: default config plus an 8x4 LSB-first
// instance and a single-chunk instance sharing clock and reset.
module tb_word_assembler;

  logic CLK;
  logic RESET;

  // Instance A: IN_W=4, NCHUNKS=2, MSB_FIRST=1
  logic       a_valid, a_abort, a_ready;
  logic [3:0] a_din;
  logic [1:0] a_en;
  logic       a_opv, a_busy;
  logic [7:0] a_dout;
  logic [1:0] a_cnt;

  // Instance B: IN_W=8, NCHUNKS=4, MSB_FIRST=0
  logic        b_valid, b_abort, b_ready;
  logic [7:0]  b_din;
  logic [3:0]  b_en;
  logic        b_opv, b_busy;
  logic [31:0] b_dout;
  logic [2:0]  b_cnt;

  // Instance C: IN_W=4, NCHUNKS=1, MSB_FIRST=1
  logic       c_valid, c_abort, c_ready;
  logic [3:0] c_din;
  logic [0:0] c_en;
  logic       c_opv, c_busy;
  logic [3:0] c_dout;
  logic [0:0] c_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  word_assembler u_a (
    .CLK(CLK), .RESET(RESET), .valid(a_valid), .DATA_IN(a_din),
    .abort(a_abort), .op_ready(a_ready), .en(a_en), .op_valid(a_opv),
    .DATA_OUT(a_dout), .chunk_cnt(a_cnt), .busy(a_busy)
  );

  word_assembler #(.IN_W(8), .NCHUNKS(4), .MSB_FIRST(0)) u_b (
    .CLK(CLK), .RESET(RESET), .valid(b_valid), .DATA_IN(b_din),
    .abort(b_abort), .op_ready(b_ready), .en(b_en), .op_valid(b_opv),
    .DATA_OUT(b_dout), .chunk_cnt(b_cnt), .busy(b_busy)
  );

  word_assembler #(.IN_W(4), .NCHUNKS(1), .MSB_FIRST(1)) u_c (
    .CLK(CLK), .RESET(RESET), .valid(c_valid), .DATA_IN(c_din),
    .abort(c_abort), .op_ready(c_ready), .en(c_en), .op_valid(c_opv),
    .DATA_OUT(c_dout), .chunk_cnt(c_cnt), .busy(c_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Move to the falling edge where inputs are changed
  task automatic fall();
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1;
    a_valid = 0; a_abort = 0; a_ready = 0; a_din = '0;
    b_valid = 0; b_abort = 0; b_ready = 0; b_din = '0;
    c_valid = 0; c_abort = 0; c_ready = 0; c_din = '0;
    #1 RESET = 1'b0;
    #2;
    chk("rst_en",   32'(a_en),   32'h0);
    chk("rst_opv",  32'(a_opv),  32'h0);
    chk("rst_dout", 32'(a_dout), 32'h0);
    chk("rst_cnt",  32'(a_cnt),  32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    fall();
    RESET = 1'b1;

    // Two-chunk assembly, MSB first
    fall(); a_valid = 1; a_din = 4'hF; a_ready = 0;
    #1 chk("t1_en0", 32'(a_en), 32'h2);
    tick();
    chk("t1_dout_early", 32'(a_dout), 32'h00);
    chk("t1_opv_early",  32'(a_opv),  32'h0);
    chk("t1_cnt1",       32'(a_cnt),  32'h1);
    chk("t1_busy1",      32'(a_busy), 32'h1);
    fall(); a_din = 4'hA;
    #1 chk("t1_en1", 32'(a_en), 32'h1);
    tick();
    chk("t1_opv",  32'(a_opv),  32'h1);
    chk("t1_dout", 32'(a_dout), 32'hFA);
    chk("t1_cnt0", 32'(a_cnt),  32'h0);
    chk("t1_busy0", 32'(a_busy), 32'h0);

    // Backpressure: DONE holds, new chunks ignored
    for (int i = 0; i < 3; i++) begin
      fall(); a_valid = 1; a_din = 4'h3; a_ready = 0;
      #1 chk("t2_en", 32'(a_en), 32'h0);
      tick();
      chk("t2_dout", 32'(a_dout), 32'hFA);
      chk("t2_opv",  32'(a_opv),  32'h1);
      chk("t2_busy", 32'(a_busy), 32'h0);
      chk("t2_cnt",  32'(a_cnt),  32'h0);
    end
    fall(); a_valid = 0; a_ready = 1;
    #1 chk("t2_en_rel", 32'(a_en), 32'h0);
    tick();
    chk("t2_opv_drop", 32'(a_opv),  32'h0);
    chk("t2_dout_kept", 32'(a_dout), 32'hFA);

    // Stall mid-word
    fall(); a_ready = 0; a_valid = 1; a_din = 4'hD;
    #1 chk("t3_en0", 32'(a_en), 32'h2);
    tick();
    for (int i = 0; i < 2; i++) begin
      fall(); a_valid = 0; a_din = 4'h9;
      #1 chk("t3_stall_en", 32'(a_en), 32'h0);
      tick();
      chk("t3_stall_busy", 32'(a_busy), 32'h1);
      chk("t3_stall_cnt",  32'(a_cnt),  32'h1);
      chk("t3_stall_opv",  32'(a_opv),  32'h0);
    end
    fall(); a_valid = 1; a_din = 4'h5;
    #1 chk("t3_en1", 32'(a_en), 32'h1);
    tick();
    chk("t3_dout", 32'(a_dout), 32'hD5);
    chk("t3_opv",  32'(a_opv),  32'h1);

    // Back-to-back streaming: word D5 consumed as chunk 1 is captured
    fall(); a_ready = 1; a_valid = 1; a_din = 4'h1;
    #1 chk("t4_en_c1", 32'(a_en), 32'h2);
    tick();
    chk("t4_opv_c1",  32'(a_opv),  32'h0);
    chk("t4_busy_c1", 32'(a_busy), 32'h1);
    chk("t4_dout_c1", 32'(a_dout), 32'hD5);
    fall(); a_din = 4'h2;
    #1 chk("t4_en_c2", 32'(a_en), 32'h1);
    tick();
    chk("t4_dout_12", 32'(a_dout), 32'h12);
    chk("t4_opv_12",  32'(a_opv),  32'h1);
    fall(); a_din = 4'h3;
    #1 chk("t4_en_c3", 32'(a_en), 32'h2);
    tick();
    chk("t4_dout_hold", 32'(a_dout), 32'h12);
    chk("t4_busy_c3",   32'(a_busy), 32'h1);
    fall(); a_din = 4'h4;
    #1 chk("t4_en_c4", 32'(a_en), 32'h1);
    tick();
    chk("t4_dout_34", 32'(a_dout), 32'h34);
    chk("t4_opv_34",  32'(a_opv),  32'h1);
    fall(); a_valid = 0;
    tick();
    chk("t4_opv_done", 32'(a_opv), 32'h0);

    // Abort mid-word
    fall(); a_ready = 0; a_valid = 1; a_din = 4'h7;
    tick();
    chk("t5_cnt_pre", 32'(a_cnt), 32'h1);
    fall(); a_abort = 1; a_valid = 1; a_ready = 1; a_din = 4'h9;
    #1 chk("t5_abort_en", 32'(a_en), 32'h0);
    tick();
    chk("t5_abort_busy", 32'(a_busy), 32'h0);
    chk("t5_abort_cnt",  32'(a_cnt),  32'h0);
    chk("t5_abort_opv",  32'(a_opv),  32'h0);
    chk("t5_abort_dout", 32'(a_dout), 32'h34);
    // Fresh word after abort starts from chunk 0
    fall(); a_abort = 0; a_ready = 0; a_valid = 1; a_din = 4'h6;
    #1 chk("t5_post_en", 32'(a_en), 32'h2);
    tick();
    fall(); a_din = 4'h8;
    tick();
    chk("t5_post_dout", 32'(a_dout), 32'h68);
    // Asynchronous reset between edges mid-word
    fall(); a_ready = 1; a_valid = 1; a_din = 4'h2;
    tick();
    chk("t5_mid_busy", 32'(a_busy), 32'h1);
    #2 RESET = 1'b0;
    #1;
    chk("t5_rst_dout", 32'(a_dout), 32'h0);
    chk("t5_rst_opv",  32'(a_opv),  32'h0);
    chk("t5_rst_cnt",  32'(a_cnt),  32'h0);
    chk("t5_rst_busy", 32'(a_busy), 32'h0);
    chk("t5_rst_en",   32'(a_en),   32'h0);
    fall(); RESET = 1'b1; a_valid = 0; a_ready = 0;

    // 8-bit x4, LSB first
    fall(); b_valid = 1; b_din = 8'h11;
    #1 chk("t6b_en0", 32'(b_en), 32'h1);
    tick();
    fall(); b_din = 8'h22;
    #1 chk("t6b_en1", 32'(b_en), 32'h2);
    tick();
    chk("t6b_cnt2", 32'(b_cnt), 32'h2);
    fall(); b_din = 8'h33;
    #1 chk("t6b_en2", 32'(b_en), 32'h4);
    tick();
    chk("t6b_dout_early", b_dout, 32'h0);
    chk("t6b_opv_early",  32'(b_opv), 32'h0);
    fall(); b_din = 8'h44;
    #1 chk("t6b_en3", 32'(b_en), 32'h8);
    tick();
    chk("t6b_dout", b_dout, 32'h44332211);
    chk("t6b_opv",  32'(b_opv), 32'h1);
    chk("t6b_cnt0", 32'(b_cnt), 32'h0);
    fall(); b_valid = 0;

    // Single-chunk streaming: one word per cycle, op_valid stays high
    fall(); c_ready = 1; c_valid = 1; c_din = 4'h5;
    #1 chk("t6c_en", 32'(c_en), 32'h1);
    tick();
    chk("t6c_dout5", 32'(c_dout), 32'h5);
    chk("t6c_opv5",  32'(c_opv),  32'h1);
    fall(); c_din = 4'h6;
    #1 chk("t6c_en_done", 32'(c_en), 32'h1);
    tick();
    chk("t6c_dout6", 32'(c_dout), 32'h6);
    chk("t6c_opv6",  32'(c_opv),  32'h1);
    fall(); c_din = 4'h7;
    tick();
    chk("t6c_dout7", 32'(c_dout), 32'h7);
    chk("t6c_opv7",  32'(c_opv),  32'h1);
    chk("t6c_busy",  32'(c_busy), 32'h0);
    fall(); c_valid = 0;
    tick();
    chk("t6c_opv_drop", 32'(c_opv), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
